mux_arb2: RTL and testbench

MUX_ARB2 -- requirements
Module: mux_arb2

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux21_reg.sv | 28 ++
 rtl/mux_arb2.sv | 107 ++++++++++
 tb/tb_mux_arb2.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester mux arbiter.
// State encodings double as the one-hot-or-zero grant vector.
package mux_arb_pkg;

   localparam int unsigned DefDw      = 8;
   localparam int unsigned DefMaxHold = 4;
   localparam int unsigned HoldCntW   = 4;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StGnt0 = 2'b01,
      StGnt1 = 2'b10
   } arb_state_e;

   function automatic arb_state_e gnt_state(input logic k);
      return k ? StGnt1 : StGnt0;
   endfunction

endpackage

// File: rtl/mux21_reg.sv
// Registered 2:1 mux with load enable; clears on synchronous reset.
module mux21_reg #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic          s,
   input  logic          en,
   output logic [DW-1:0] o
);

   logic [DW-1:0] o_q, o_d;

   always_comb begin
      o_d = o_q;
      if (en) o_d = s ? i1 : i0;
   end

   always_ff @(posedge clk) begin
      if (rst) o_q <= '0;
      else     o_q <= o_d;
   end

   assign o = o_q;

endmodule

// File: rtl/mux_arb2.sv
// Two-requester arbiter driving a shared registered 2:1 mux.
// Define MUX_ARB2_TIMEOUT_EN to force grant rotation after MAX_HOLD cycles under contention.
module mux_arb2
   import mux_arb_pkg::*;
#(
   parameter int unsigned DW       = DefDw,
   parameter int unsigned MAX_HOLD = DefMaxHold
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [DW-1:0] d0,
   input  logic [DW-1:0] d1,
   output logic [1:0]    gnt,
   output logic          sel,
   output logic [DW-1:0] o,
   output logic          o_valid
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       o_valid_q;
   logic       cur_k;
   logic       load_en;
   logic       force_rel;

   assign cur_k = (state_q == StGnt1);

`ifdef MUX_ARB2_TIMEOUT_EN
   localparam logic [HoldCntW-1:0] HoldMax = HoldCntW'(MAX_HOLD - 1);

   logic [HoldCntW-1:0] hold_q, hold_d;

   assign force_rel = (state_q != StIdle) && (hold_q == HoldMax) && req[~cur_k];

   always_comb begin
      hold_d = '0;
      // Staying in the same grant counts up and saturates; any entry or idle restarts at zero.
      if (state_q != StIdle && state_d == state_q) begin
         hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
   end
`else
   logic unused_max_hold;
   assign unused_max_hold = ^32'(MAX_HOLD);
   assign force_rel       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            case (req)
               2'b01:   state_d = StGnt0;
               2'b10:   state_d = StGnt1;
               2'b11:   state_d = gnt_state(~last_q);
               default: state_d = StIdle;
            endcase
         end
         StGnt0, StGnt1: begin
            if (!req[cur_k]) begin
               state_d = req[~cur_k] ? gnt_state(~cur_k) : StIdle;
            end else if (force_rel) begin
               state_d = gnt_state(~cur_k);
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != StIdle && state_d != state_q) last_d = (state_d == StGnt1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         o_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         o_valid_q <= load_en;
      end
   end

   assign gnt     = state_q;
   assign sel     = gnt[1];
   assign load_en = (state_q == StGnt0 && req[0]) || (state_q == StGnt1 && req[1]);
   assign o_valid = o_valid_q;

   mux21_reg #(
      .DW(DW)
   ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .i0  (d0),
      .i1  (d1),
      .s   (sel),
      .en  (load_en),
      .o   (o)
   );

endmodule

// File: tb/tb_mux_arb2.sv
// Self-checking bench for mux_arb2: cycle model feeding a scoreboard plus directed checks.
module tb_mux_arb2;

   localparam int unsigned MaxHold = 4;
`ifdef MUX_ARB2_TIMEOUT_EN
   localparam bit TmoEn = 1'b1;
`else
   localparam bit TmoEn = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] gnt;
      logic [7:0] o;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [7:0] d0  = 8'h00;
   logic [7:0] d1  = 8'h00;
   logic [1:0] gnt;
   logic       sel;
   logic [7:0] o;
   logic       o_valid;

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb_q[$];

   // Reference model state: 0 idle, 1 grant0, 2 grant1.
   int         m_st   = 0;
   logic       m_last = 1'b1;
   int         m_cnt  = 0;
   logic [7:0] m_o    = 8'h00;
   logic       m_v    = 1'b0;

   always #5 clk = ~clk;

   mux_arb2 #(
      .DW       (8),
      .MAX_HOLD (MaxHold)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .d0      (d0),
      .d1      (d1),
      .gnt     (gnt),
      .sel     (sel),
      .o       (o),
      .o_valid (o_valid)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_step(input logic r, input logic [1:0] rq, input logic [7:0] a,
                             input logic [7:0] b);
      int   nst;
      logic k;
      if (r) begin
         m_st = 0; m_last = 1'b1; m_cnt = 0; m_o = 8'h00; m_v = 1'b0;
         return;
      end
      if (m_st == 1 && rq[0])      begin m_o = a; m_v = 1'b1; end
      else if (m_st == 2 && rq[1]) begin m_o = b; m_v = 1'b1; end
      else                         m_v = 1'b0;
      nst = m_st;
      if (m_st == 0) begin
         if (rq == 2'b01)      nst = 1;
         else if (rq == 2'b10) nst = 2;
         else if (rq == 2'b11) nst = m_last ? 1 : 2;
      end else begin
         k = (m_st == 2);
         if (!rq[k])                                          nst = rq[!k] ? (k ? 1 : 2) : 0;
         else if (TmoEn && m_cnt == MaxHold - 1 && rq[!k])    nst = k ? 1 : 2;
      end
      if (nst != 0 && nst != m_st) begin
         m_last = (nst == 2);
         m_cnt  = 0;
      end else if (nst != 0) begin
         if (m_cnt < MaxHold - 1) m_cnt++;
      end else begin
         m_cnt = 0;
      end
      m_st = nst;
   endtask

   task automatic step(input logic r, input logic [1:0] rq, input logic [7:0] a,
                       input logic [7:0] b);
      exp_t e;
      @(negedge clk);
      rst = r; req = rq; d0 = a; d1 = b;
      model_step(r, rq, a, b);
      sb_q.push_back('{gnt: 2'(m_st), o: m_o, v: m_v});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq("sb_gnt", 32'(gnt), 32'(e.gnt));
      check_eq("sb_o", 32'(o), 32'(e.o));
      check_eq("sb_valid", 32'(o_valid), 32'(e.v));
      check_eq("sel_eq_gnt1", 32'(sel), 32'(gnt[1]));
      check_eq("gnt_not_11", 32'(gnt == 2'b11), 32'(0));
   endtask

   initial begin
      // Reset state
      step(1'b1, 2'b00, 8'h00, 8'h00);
      step(1'b1, 2'b11, 8'h11, 8'h22);
      check_eq("rst_gnt", 32'(gnt), 32'h0);
      check_eq("rst_o", 32'(o), 32'h0);
      check_eq("rst_valid", 32'(o_valid), 32'h0);

      // First tie goes to requester 0, data one cycle later
      step(1'b0, 2'b11, 8'hA5, 8'h3C);
      check_eq("tie0_gnt", 32'(gnt), 32'h1);
      check_eq("tie0_valid", 32'(o_valid), 32'h0);
      step(1'b0, 2'b11, 8'hA5, 8'h3C);
      check_eq("lat_o", 32'(o), 32'hA5);
      check_eq("lat_valid", 32'(o_valid), 32'h1);

      // Direct handover 0 -> 1 without an idle bubble
      step(1'b0, 2'b10, 8'hA5, 8'h3C);
      check_eq("sw_gnt", 32'(gnt), 32'h2);
      check_eq("sw_valid", 32'(o_valid), 32'h0);
      step(1'b0, 2'b10, 8'hA5, 8'h3C);
      check_eq("sw_o", 32'(o), 32'h3C);
      check_eq("sw_o_valid", 32'(o_valid), 32'h1);

      // Reset mid-grant drops everything; next tie back to requester 0
      step(1'b1, 2'b10, 8'h5A, 8'hC3);
      check_eq("midrst_gnt", 32'(gnt), 32'h0);
      check_eq("midrst_o", 32'(o), 32'h0);
      check_eq("midrst_valid", 32'(o_valid), 32'h0);
      step(1'b0, 2'b11, 8'h5A, 8'hC3);
      check_eq("postrst_gnt", 32'(gnt), 32'h1);

      // Ties through idle alternate 0,1,0,1
      step(1'b1, 2'b00, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 2'b11, 8'(i), 8'(i + 8'h40));
         check_eq("alt_gnt", 32'(gnt), (i % 2 != 0) ? 32'h2 : 32'h1);
         step(1'b0, 2'b00, 8'h00, 8'h00);
         check_eq("alt_idle", 32'(gnt), 32'h0);
      end

      // Sustained contention: rotation with timeout, otherwise requester 0 keeps it
      step(1'b1, 2'b00, 8'h00, 8'h00);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 2'b11, 8'h10 + 8'(i), 8'h80 + 8'(i));
         check_eq("hold11_gnt", 32'(gnt),
                  (TmoEn && ((i / MaxHold) % 2 != 0)) ? 32'h2 : 32'h1);
      end

      // Lone requester is never forced off
      step(1'b1, 2'b00, 8'h00, 8'h00);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 2'b01, 8'h20 + 8'(i), 8'hEE);
         check_eq("hold01_gnt", 32'(gnt), 32'h1);
      end

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
